div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider for the execute stage of the MIPS pipeline. It consumes the decoded divide request (DIV/DIVU) together with the E-stage operands and produces a 64-bit {hi, lo} result for the HI/LO register write. While an operation is in flight it drives a stall request to the hazard unit. Completion takes a fixed 32 iterations, and the operation can be cancelled by an E-stage flush.

---
 rtl/div_unit_pkg.sv | 13 +
 rtl/div_unit.sv | 112 +++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Holds the FSM state encoding and the default operand width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } divState_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU) for the execute stage.
// Ports: clk, rst (async active-low); startE/signedE/flushE requests;
// srcaE dividend, srcbE divisor; busyE, readyE, stallE status;
// resultE = {hi = remainder, lo = quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startE,
    input  logic               signedE,
    input  logic               flushE,
    input  logic [WIDTH-1:0]   srcaE,
    input  logic [WIDTH-1:0]   srcbE,
    output logic               busyE,
    output logic               readyE,
    output logic               stallE,
    output logic [2*WIDTH-1:0] resultE
);

    localparam int DIV_STEPS = WIDTH;
    localparam int CW = $clog2(DIV_STEPS);

    divState_t state, stateNext;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             qneg;
    logic             rneg;

    logic             go;
    logic             lastStep;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] qFinal;
    logic [WIDTH-1:0] rFinal;

    assign go       = (state == IDLE) && startE && !flushE;
    assign lastStep = (state == BUSY) && (cnt == CW'(DIV_STEPS - 1));

    assign busyE  = (state == BUSY);
    assign readyE = (state == DONE);
    assign stallE = go || busyE;

    // Magnitudes; -0x80000000 wraps back to 0x80000000, read as unsigned.
    assign absA = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign absB = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    // One restoring step: compare and subtract at WIDTH+1 bits so the
    // shifted-out remainder MSB is not lost.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        ge      = (shifted >= {1'b0, dvs});
        remNext = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoNext = {quo[WIDTH-2:0], ge};
        qFinal  = qneg ? -quoNext : quoNext;
        rFinal  = rneg ? -remNext : remNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (go) stateNext = BUSY;
            BUSY:    if (lastStep) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flushE) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            resultE <= '0;
        end else if (flushE) begin
            cnt <= '0;
        end else if (go) begin
            quo  <= absA;
            dvs  <= absB;
            rem  <= '0;
            cnt  <= '0;
            qneg <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            rneg <= signedE && srcaE[WIDTH-1];
        end else if (state == BUSY) begin
            rem <= remNext;
            quo <= quoNext;
            cnt <= cnt + CW'(1);
            if (lastStep) resultE <= {rFinal, qFinal};
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Drives on the falling edge and samples just after it.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic        signedE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        busyE;
    logic        readyE;
    logic        stallE;
    logic [63:0] resultE;

    int nAssert = 0;
    int nFail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .startE(startE),
        .signedE(signedE),
        .flushE(flushE),
        .srcaE(srcaE),
        .srcbE(srcbE),
        .busyE(busyE),
        .readyE(readyE),
        .stallE(stallE),
        .resultE(resultE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide and follow it through to DONE.
    task automatic runDiv(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp);
        int stallCnt;
        @(negedge clk);
        srcaE = a;
        srcbE = b;
        signedE = sgn;
        startE = 1'b1;
        #1;
        stallCnt = stallE ? 1 : 0;
        @(negedge clk);
        startE = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stallE) break;
            stallCnt++;
            @(negedge clk);
        end
        check({tag, "_stall"}, 64'(stallCnt), 64'd33);
        check({tag, "_ready"}, {63'd0, readyE}, 64'd1);
        check({tag, "_result"}, resultE, exp);
        @(negedge clk);
        #1;
        check({tag, "_readyLow"}, {63'd0, readyE}, 64'd0);
    endtask

    initial begin
        logic readySeen;
        rst = 1'b0;
        startE = 1'b0;
        signedE = 1'b0;
        flushE = 1'b0;
        srcaE = '0;
        srcbE = '0;
        #1;
        check("rstBusy", {63'd0, busyE}, 64'd0);
        check("rstReady", {63'd0, readyE}, 64'd0);
        check("rstStall", {63'd0, stallE}, 64'd0);
        check("rstResult", resultE, 64'd0);
        startE = 1'b1;
        #1;
        check("rstStallComb", {63'd0, stallE}, 64'd1);
        startE = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        runDiv("u100d7", 32'd100, 32'd7, 1'b0,
               {32'h00000002, 32'h0000000E});
        runDiv("sM7d2", 32'hFFFFFFF9, 32'd2, 1'b1,
               {32'hFFFFFFFF, 32'hFFFFFFFD});
        runDiv("s7dM2", 32'd7, 32'hFFFFFFFE, 1'b1,
               {32'h00000001, 32'hFFFFFFFD});
        runDiv("sOvf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
               {32'h00000000, 32'h80000000});
        runDiv("uMin", 32'h80000000, 32'hFFFFFFFF, 1'b0,
               {32'h80000000, 32'h00000000});
        runDiv("u5d0", 32'd5, 32'd0, 1'b0,
               {32'h00000005, 32'hFFFFFFFF});
        runDiv("sM5d0", 32'hFFFFFFFB, 32'd0, 1'b1,
               {32'hFFFFFFFB, 32'h00000001});

        // Cancel in BUSY cycle 10.
        @(negedge clk);
        srcaE = 32'd1000;
        srcbE = 32'd3;
        signedE = 1'b0;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("flushPreBusy", {63'd0, busyE}, 64'd1);
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0;
        #1;
        check("flushIdle", {63'd0, busyE}, 64'd0);
        check("flushStall", {63'd0, stallE}, 64'd0);
        readySeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (readyE) readySeen = 1'b1;
        end
        check("flushNoReady", {63'd0, readySeen}, 64'd0);
        check("flushKeep", resultE, {32'hFFFFFFFB, 32'h00000001});

        // Start and flush together in IDLE.
        @(negedge clk);
        startE = 1'b1;
        flushE = 1'b1;
        #1;
        check("collStall", {63'd0, stallE}, 64'd0);
        @(negedge clk);
        #1;
        check("collBusy", {63'd0, busyE}, 64'd0);
        startE = 1'b0;
        flushE = 1'b0;

        // startE held through DONE: restart only after the IDLE cycle.
        @(negedge clk);
        srcaE = 32'd9;
        srcbE = 32'd4;
        startE = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busyE) break;
            @(negedge clk);
        end
        check("holdReady", {63'd0, readyE}, 64'd1);
        check("holdDoneStall", {63'd0, stallE}, 64'd0);
        check("holdResult", resultE, {32'd1, 32'd2});
        @(negedge clk);
        #1;
        check("holdIdleBusy", {63'd0, busyE}, 64'd0);
        check("holdIdleStall", {63'd0, stallE}, 64'd1);
        @(negedge clk);
        #1;
        check("holdRestart", {63'd0, busyE}, 64'd1);
        startE = 1'b0;
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0;

        // Async reset mid-BUSY.
        @(negedge clk);
        srcaE = 32'd50;
        srcbE = 32'd5;
        startE = 1'b1;
        @(negedge clk);
        startE = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arstBusy", {63'd0, busyE}, 64'd0);
        check("arstStall", {63'd0, stallE}, 64'd0);
        check("arstResult", resultE, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        runDiv("postRst", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
